// File: rtl/teller_dispatcher_pkg.sv
// Shared constants for the teller dispatcher: FSM encoding, teller ids and
// the default busy hold time.
package teller_dispatcher_pkg;

   typedef logic [1:0] teller_id_t;
   typedef logic [1:0] disp_state_t;

   localparam disp_state_t ST_IDLE = 2'd0;
   localparam disp_state_t ST_CALL = 2'd1;
   localparam disp_state_t ST_COOL = 2'd2;

   localparam teller_id_t TELLER_NONE  = 2'd0;
   localparam teller_id_t TELLER_ONE   = 2'd1;
   localparam teller_id_t TELLER_TWO   = 2'd2;
   localparam teller_id_t TELLER_THREE = 2'd3;

   localparam int DEF_HOLD_CYCLES = 16;

   // One-hot mask of a teller id; TELLER_NONE maps to an empty mask.
   function automatic logic [2:0] teller_mask(input teller_id_t t);
      logic [2:0] m;
      case (t)
         TELLER_ONE:   m = 3'b001;
         TELLER_TWO:   m = 3'b010;
         TELLER_THREE: m = 3'b100;
         default:      m = 3'b000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/teller_dispatcher_if.sv
// Bundle of the dispatcher's teller/queue-side signals.
interface teller_dispatcher_if #(
   parameter int TICKET_W = 4
);
   logic [2:0]          teller_req;
   logic [2:0]          pcount;
   logic                dequeue;
   logic [1:0]          call_teller;
   logic [TICKET_W-1:0] ticket;
   logic [2:0]          teller_busy;

   modport master (
      output teller_req, pcount,
      input  dequeue, call_teller, ticket, teller_busy
   );

   modport slave (
      input  teller_req, pcount,
      output dequeue, call_teller, ticket, teller_busy
   );
endinterface

// File: rtl/teller_dispatcher_service_timer.sv
// Per-teller busy timer: loads the hold time on a call, counts down and
// keeps the busy flag high until the count reaches zero.
module teller_service_timer #(
   parameter int HOLD_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic busy
);
   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

   logic [CNT_W-1:0] count_r;
   logic             busy_r;

   // Load on a call, otherwise count down; busy drops on the 1->0 step.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {CNT_W{1'b0}};
         busy_r  <= 1'b0;
      end else if (load) begin
         count_r <= CNT_W'(HOLD_CYCLES);
         busy_r  <= 1'b1;
      end else if (count_r != {CNT_W{1'b0}}) begin
         count_r <= count_r - CNT_W'(1);
         if (count_r == CNT_W'(1)) begin
            busy_r <= 1'b0;
         end
      end
   end

   assign busy = busy_r;
endmodule

// File: rtl/teller_dispatcher.sv
// Teller dispatcher: captures teller ready presses, arbitrates round-robin
// and calls the next customer with a one-cycle dequeue pulse.
module teller_dispatcher
   import teller_dispatcher_pkg::*;
#(
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int TICKET_W    = 4
) (
   input logic                clk,
   input logic                rst,
   teller_dispatcher_if.slave bus
);
   disp_state_t         state_r, state_nxt_s;
   logic [2:0]          req_q_r;
   logic [2:0]          pending_r, pending_nxt_s;
   teller_id_t          ptr_r;
   teller_id_t          grant_s;
   teller_id_t          call_r;
   logic [TICKET_W-1:0] ticket_r;
   logic                dequeue_r;
   logic                start_s;
   logic [2:0]          grant_mask_s;
   logic [2:0]          set_s;
   logic [2:0]          busy_s;

   // Round-robin pick among pending tellers, starting after the pointer.
   always_comb begin
      grant_s = TELLER_NONE;
      case (ptr_r)
         TELLER_ONE: begin
            if (pending_r[1])      grant_s = TELLER_TWO;
            else if (pending_r[2]) grant_s = TELLER_THREE;
            else if (pending_r[0]) grant_s = TELLER_ONE;
            else                   grant_s = TELLER_NONE;
         end
         TELLER_TWO: begin
            if (pending_r[2])      grant_s = TELLER_THREE;
            else if (pending_r[0]) grant_s = TELLER_ONE;
            else if (pending_r[1]) grant_s = TELLER_TWO;
            else                   grant_s = TELLER_NONE;
         end
         default: begin
            if (pending_r[0])      grant_s = TELLER_ONE;
            else if (pending_r[1]) grant_s = TELLER_TWO;
            else if (pending_r[2]) grant_s = TELLER_THREE;
            else                   grant_s = TELLER_NONE;
         end
      endcase
   end

   // Call decision, pending update from fresh presses, and next FSM state.
   always_comb begin
      start_s       = (state_r == ST_IDLE) && (pending_r != 3'b000) && (bus.pcount != 3'd0);
      grant_mask_s  = start_s ? teller_mask(grant_s) : 3'b000;
      set_s         = bus.teller_req & ~req_q_r & ~busy_s & ~pending_r;
      pending_nxt_s = (pending_r & ~grant_mask_s) | set_s;
      case (state_r)
         ST_IDLE: begin
            if (start_s) state_nxt_s = ST_CALL;
            else         state_nxt_s = ST_IDLE;
         end
         ST_CALL: state_nxt_s = ST_COOL;
         ST_COOL: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Control registers: FSM, request history, pending set, pointer and displays.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         req_q_r   <= 3'b000;
         pending_r <= 3'b000;
         ptr_r     <= TELLER_THREE;
         call_r    <= TELLER_NONE;
         ticket_r  <= {TICKET_W{1'b0}};
         dequeue_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         req_q_r   <= bus.teller_req;
         pending_r <= pending_nxt_s;
         dequeue_r <= start_s;
         if (start_s) begin
            ptr_r    <= grant_s;
            call_r   <= grant_s;
            ticket_r <= ticket_r + TICKET_W'(1);
         end
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_timer
      teller_service_timer #(
         .HOLD_CYCLES(HOLD_CYCLES)
      ) u_timer (
         .clk  (clk),
         .rst  (rst),
         .load (grant_mask_s[i]),
         .busy (busy_s[i])
      );
   end

   assign bus.dequeue     = dequeue_r;
   assign bus.call_teller = call_r;
   assign bus.ticket      = ticket_r;
   assign bus.teller_busy = busy_s;
endmodule

// File: tb/tb_teller_dispatcher.sv
// Randomised and directed bench for teller_dispatcher with a timestamp-based
// reference model and a dequeue scoreboard.
module tb_teller_dispatcher;
   localparam int HOLD = 16;
   localparam int TW   = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   teller_dispatcher_if #(.TICKET_W(TW)) bus ();

   teller_dispatcher #(.HOLD_CYCLES(HOLD), .TICKET_W(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int teller;
      int tk;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state: expressed as timestamps of calls
   int       cyc = 0;
   bit [2:0] m_pend = 3'b000;
   bit [2:0] m_prev = 3'b000;
   int       m_busy_end[3] = '{0, 0, 0};
   int       m_last_call = -10;
   int       m_ptr = 3;
   int       m_tk = 0;
   int       m_call = 0;
   bit [2:0] exp_busy = 3'b000;
   bit       mon_en = 1'b0;
   bit       saw_wrap = 1'b0;
   int       last_deq_tk = -1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // One model step per rising edge, using inputs as they were before it.
   task automatic model_step();
      bit [2:0] req;
      bit [2:0] old_pend;
      int       g;
      int       c;
      cyc++;
      req = bus.teller_req;
      if (rst) begin
         m_pend = 3'b000;
         m_prev = 3'b000;
         for (int i = 0; i < 3; i++) m_busy_end[i] = 0;
         m_last_call = -10;
         m_ptr = 3;
         m_tk = 0;
         m_call = 0;
      end else begin
         old_pend = m_pend;
         if (cyc >= m_last_call + 3 && old_pend != 3'b000 && bus.pcount != 3'd0) begin
            g = 0;
            for (int k = 1; k <= 3; k++) begin
               c = ((m_ptr - 1 + k) % 3) + 1;
               if (g == 0 && old_pend[c-1]) g = c;
            end
            m_pend[g-1] = 1'b0;
            m_busy_end[g-1] = cyc + HOLD;
            m_last_call = cyc;
            m_ptr = g;
            m_call = g;
            m_tk = (m_tk + 1) % (1 << TW);
            sb.push_back('{cyc: cyc, teller: g, tk: m_tk});
         end
         for (int i = 0; i < 3; i++) begin
            if (req[i] && !m_prev[i] && !(cyc <= m_busy_end[i]) && !old_pend[i])
               m_pend[i] = 1'b1;
         end
         m_prev = req;
      end
      for (int i = 0; i < 3; i++) exp_busy[i] = (cyc < m_busy_end[i]);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         mon_en = 1'b1;
      end
   end

   // Monitor: compare DUT outputs against the model mid-cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check("dequeue_pulse", int'(bus.dequeue), 1);
            check("call_teller_at_call", int'(bus.call_teller), e.teller);
            check("ticket_at_call", int'(bus.ticket), e.tk);
         end else begin
            check("no_dequeue", int'(bus.dequeue), 0);
         end
         if (bus.dequeue) begin
            check("dequeue_implies_pcount_nonzero", int'(bus.pcount != 3'd0), 1);
            if (bus.ticket == '0 && last_deq_tk == (1 << TW) - 1) saw_wrap = 1'b1;
            last_deq_tk = int'(bus.ticket);
         end
         check("teller_busy", int'(bus.teller_busy), int'(exp_busy));
         check("call_teller", int'(bus.call_teller), m_call);
         check("ticket", int'(bus.ticket), m_tk);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [2:0] r);
      bus.teller_req = r;
      cycles(1);
      bus.teller_req = 3'b000;
   endtask

   initial begin
      bus.teller_req = 3'($urandom_range(0, 7));
      bus.pcount     = 3'($urandom_range(0, 7));
      rst = 1'b1;
      cycles(2);
      bus.teller_req = 3'b000;
      rst = 1'b0;
      cycles(2);

      // single call
      bus.pcount = 3'd3;
      bus.teller_req = 3'b001;
      cycles(3);
      bus.teller_req = 3'b000;
      cycles(20);

      // simultaneous burst, then a second burst once all idle
      press(3'b111);
      cycles(25);
      press(3'b111);
      cycles(25);

      // empty queue holds the request
      bus.pcount = 3'd0;
      press(3'b010);
      cycles(20);
      bus.pcount = 3'd1;
      cycles(20);

      // busy teller presses are ignored
      bus.pcount = 3'd3;
      press(3'b100);
      cycles(4);
      press(3'b100);
      cycles(20);
      press(3'b100);
      cycles(20);

      // reset while cooling down with two tellers pending
      bus.pcount = 3'd0;
      press(3'b111);
      cycles(2);
      bus.pcount = 3'd1;
      cycles(2);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      cycles(20);

      // enough calls to wrap the ticket
      bus.pcount = 3'd5;
      repeat (7) begin
         press(3'b111);
         cycles(19);
      end

      // random traffic
      repeat (800) begin
         if ($urandom_range(0, 3) == 0)
            bus.teller_req = bus.teller_req ^ (3'b001 << $urandom_range(0, 2));
         if ($urandom_range(0, 15) == 0)
            bus.pcount = 3'($urandom_range(0, 7));
         rst = ($urandom_range(0, 149) == 0);
         cycles(1);
      end
      rst = 1'b0;
      bus.teller_req = 3'b000;
      cycles(25);

      check("ticket_wrapped", int'(saw_wrap), 1);
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/teller_dispatcher.md
Name: teller_dispatcher

Overview:
- Service-side counterpart of the customer-entry path. Entry sensors raise the queue count; this block lowers it.
- Watches the three teller "ready" buttons and arbitrates round-robin among the tellers that are ready.
- When the queue is non-empty, it calls the next customer to the granted teller and issues a one-cycle dequeue pulse. That pulse drives the queue counter's Down input.
- Tracks per-teller busy time and a wrapping serving-ticket number for the displays.

Parameters:
- HOLD_CYCLES, 16, number of clk cycles a teller stays busy after a call (minimum 1).
- TICKET_W, 4, width of the serving-ticket counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- teller_req  input  3  teller ready buttons, already debounced; bit0=TellerOne, bit1=TellerTwo, bit2=TellerThree.
- pcount  input  3  current queue occupancy from the queue counter.
- dequeue  output  1  one-cycle pulse, one customer leaves the queue.
- call_teller  output  2  teller most recently called (1..3); 0 = none since reset.
- ticket  output  TICKET_W  serving number of the last call.
- teller_busy  output  3  per-teller busy flag.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - dequeue=0, call_teller=0, ticket=0, teller_busy=000.
  - pending=000, all hold counters=0, FSM=IDLE.
  - Round-robin pointer = teller 3, so teller 1 has first priority.
- Request capture:
  - teller_req is registered into req_q; edge[i] = teller_req[i] & ~req_q[i].
  - pending[i] sets on edge[i] only if teller_busy[i]=0 and pending[i]=0.
  - Edges from a busy or already-pending teller are ignored, never queued.
- Arbitration: search order starts at pointer+1 and wraps 3->1. The pointer updates to the granted teller.
- FSM states IDLE, CALL, COOL:
  - IDLE -> CALL when any pending bit is set and pcount!=0. The grant is taken on this edge.
  - On entering CALL:
    - pending[g] clears, teller_busy[g] sets, hold counter g loads HOLD_CYCLES.
    - call_teller = g; ticket increments by 1.
  - In CALL: dequeue=1, for exactly this one cycle.
  - CALL -> COOL unconditionally. COOL gives pcount one cycle to reflect the decrement.
  - COOL -> IDLE unconditionally.
- Timing:
  - Minimum spacing between dequeue pulses is 3 cycles.
  - Latency: a teller_req edge sampled at edge k sets pending after edge k. With pcount!=0 and FSM in IDLE, dequeue is high in cycle k+1..k+2.
- Empty queue:
  - pcount==0 means no dequeue is ever issued.
  - pending bits are held indefinitely; service starts 1 cycle after pcount becomes non-zero while in IDLE.
- Busy timers:
  - Each hold counter decrements every cycle while non-zero.
  - teller_busy[i] clears on the edge where the counter goes 1->0.
  - Busy is therefore high for exactly HOLD_CYCLES cycles, starting with the CALL cycle.
- Ticket: wraps from 2^TICKET_W-1 to 0.
- call_teller holds its value until the next call.
- Simultaneous edge and grant on different tellers: both take effect. Pending sets for one teller and clears for the other.
- Reset asserted in any state (including CALL/COOL) returns everything to the reset values the next cycle. Pending requests are lost.
- Invariant: dequeue=1 implies pcount!=0 in the same cycle, since pcount cannot change during CALL.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, CALL=2'd1, COOL=2'd2;
  - teller index constants: TELLER_NONE=0, TELLER_ONE=1, TELLER_TWO=2, TELLER_THREE=3;
  - default HOLD_CYCLES.
- Sub-module teller_service_timer, instantiated 3x: load, count down, busy flag.
- Arbitration and FSM stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> dequeue=0, call_teller=0, ticket=0, teller_busy=000.
- Single call: pcount=3, teller_req[0] rises -> one dequeue pulse next cycle, call_teller=1, ticket=1, teller_busy[0]=1 for exactly 16 cycles.
- All three rise together, pcount=3 -> three dequeue pulses 3 cycles apart, call_teller 1,2,3, ticket 1,2,3. A later simultaneous burst, once all are idle, is served starting at teller 1 (pointer=3).
- Empty queue: pcount=0, teller_req[1] rises -> no dequeue for 20 cycles. Set pcount=1 -> dequeue within 2 cycles, call_teller=2.
- Busy handling:
  - teller 3 presses again while busy -> ignored, no dequeue;
  - presses after teller_busy[2] clears -> served.
- Mid-operation reset and wrap:
  - rst asserted in COOL with pending=110 -> all cleared, no dequeue afterwards;
  - 16 consecutive calls -> ticket goes 15 then 0.
